// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register file defaults, address width helper and index type
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int AW_DEF = aw_of(NREG_DEF);
  typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, set on issue and cleared on write
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWP = 2,
  parameter int AW = aw_of(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWP-1:0]    we,
  input  logic [NWP*AW-1:0] wa,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy_vec
);
  logic [NREG-1:0] busy_nxt;
  always_comb begin
    busy_nxt = busy_vec;
    for (int k = 0; k < NWP; k++)
      if (we[k]) busy_nxt[wa[k*AW +: AW]] = 1'b0;
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
  end
  always_ff @(posedge clk)
    busy_vec <= rst_n ? {busy_nxt[NREG-1:1], 1'b0} : '0;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-write-port register file with optional write bypass and issue scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NWP = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW = aw_of(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       rs1_addr,
  input  logic [AW-1:0]       rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wa,
  input  logic [NWP*XLEN-1:0] wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] mem [NREG];
  logic [AW-1:0]   ra [2];
  logic [XLEN-1:0] rdat [2];
  logic            rbusy [2];
  assign ra[0] = rs1_addr;
  assign ra[1] = rs2_addr;
  // ascending port order lets the highest-index port win on address collisions
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else
      for (int k = 0; k < NWP; k++)
        if (we[k] && wa[k*AW +: AW] != '0) mem[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = mem[ra[p]];
      rbusy[p] = busy_vec[ra[p]];
      if (BYPASS)
        for (int k = 0; k < NWP; k++)
          if (we[k] && wa[k*AW +: AW] == ra[p]) begin
            rdat[p] = wd[k*XLEN +: XLEN];
            rbusy[p] = rbusy[p] && iss_valid && iss_rd == ra[p];
          end
      if (ra[p] == '0) begin
        rdat[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end
  assign rs1_data = rdat[0];
  assign rs2_data = rdat[1];
  assign rs1_busy = rbusy[0];
  assign rs2_busy = rbusy[1];
  regfile_scoreboard #(.NREG(NREG), .NWP(NWP), .AW(AW)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .wa(wa),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd),
    .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of a bypassing and a non-bypassing regfile_mp sharing stimulus
module tb_regfile_mp;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  reg_idx_t rs1_addr, rs2_addr, iss_rd;
  logic [1:0] we;
  logic [9:0] wa;
  logic [63:0] wd;
  logic iss_valid;
  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data, busy_vec, nb_busy_vec;
  logic rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  regfile_mp #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );
  regfile_mp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(nb_busy_vec)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask
  initial begin
    rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0;
    idle();
    tick(); tick();
    rst_n = 1'b1; rs1_addr = 5'd5;
    #1;
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_rd5", rs1_data, 32'h0);
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF}; rs1_addr = '0;
    tick(); idle(); rs1_addr = 5'd5;
    #1;
    chk("wr5_rd", rs1_data, 32'hDEADBEEF);
    chk("wr5_rd_nb", nb_rs1_data, 32'hDEADBEEF);
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2, 32'h1}; rs2_addr = 5'd7;
    #1;
    chk("coll_bypass", rs2_data, 32'h2);
    chk("coll_nb_old", nb_rs2_data, 32'h0);
    tick(); idle();
    #1;
    chk("coll_stored", rs2_data, 32'h2);
    chk("coll_stored_nb", nb_rs2_data, 32'h2);
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFFFFFF}; iss_valid = 1'b1; iss_rd = '0; rs1_addr = '0;
    #1;
    chk("r0_bypass", rs1_data, 32'h0);
    chk("r0_busy", {31'h0, rs1_busy}, 32'h0);
    tick(); idle();
    #1;
    chk("r0_stored", rs1_data, 32'h0);
    chk("r0_busyvec", busy_vec, 32'h0);
    iss_valid = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd9;
    tick(); idle();
    #1;
    chk("iss9_busy", {31'h0, rs1_busy}, 32'h1);
    chk("iss9_vec", busy_vec, 32'h200);
    iss_valid = 1'b1; iss_rd = 5'd9; we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h77, 32'h0};
    #1;
    chk("iss_wr_busy", {31'h0, rs1_busy}, 32'h1);
    tick(); idle();
    #1;
    chk("iss_wr_vec", busy_vec, 32'h200);
    chk("iss_wr_data", rs1_data, 32'h77);
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h99};
    #1;
    chk("wr9_busy_byp", {31'h0, rs1_busy}, 32'h0);
    chk("wr9_busy_nb", {31'h0, nb_rs1_busy}, 32'h1);
    tick(); idle();
    #1;
    chk("wr9_vec", busy_vec, 32'h0);
    chk("wr9_data", rs1_data, 32'h99);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); tick(); idle();
    #1;
    chk("reissue_vec", busy_vec, 32'h200);
    we = 2'b01; wa = {5'd0, 5'd9}; wd = '0;
    tick(); idle();
    #1;
    chk("reissue_clr", busy_vec, 32'h0);
    we = 2'b11; wa = {5'd6, 5'd4}; wd = {32'hBBBB, 32'hAAAA}; rs1_addr = 5'd4; rs2_addr = 5'd6;
    #1;
    chk("dual_p0", rs1_data, 32'hAAAA);
    chk("dual_p1", rs2_data, 32'hBBBB);
    tick(); idle();
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h11};
    tick(); idle();
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h55}; rs1_addr = 5'd3;
    #1;
    chk("nb_old", nb_rs1_data, 32'h11);
    chk("byp_new", rs1_data, 32'h55);
    tick(); idle();
    #1;
    chk("nb_new", nb_rs1_data, 32'h55);
    for (int r = 10; r < 14; r++) begin
      iss_valid = 1'b1; iss_rd = reg_idx_t'(r);
      tick();
    end
    idle();
    #1;
    chk("four_busy", busy_vec, 32'h3C00);
    rst_n = 1'b0; we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'h1234}; iss_valid = 1'b1; iss_rd = 5'd20;
    tick(); idle(); rst_n = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd7;
    #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_busy_nb", nb_busy_vec, 32'h0);
    chk("rst_rd5", rs1_data, 32'h0);
    chk("rst_rd7", rs2_data, 32'h0);
    chk("rst_rd5_nb", nb_rs1_data, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL: XLEN, 32, data width of each register.
REQ-002 SHALL: NREG, 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL: NWP, 2, number of write ports (1..4).
REQ-004 SHALL: BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.
REQ-005 SHALL: clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL: rs1_addr, rs2_addr  input  AW  read addresses.
REQ-008 SHALL: rs1_data, rs2_data  output  XLEN  combinational read data.
REQ-009 SHALL: rs1_busy, rs2_busy  output  1  combinational scoreboard state of addressed register.
REQ-010 SHALL: we  input  NWP  per-port write enable.
REQ-011 SHALL: wa  input  NWP*AW  per-port write address, port k at bits [k*AW +: AW].
REQ-012 SHALL: wd  input  NWP*XLEN  per-port write data, port k at bits [k*XLEN +: XLEN].
REQ-013 SHALL: iss_valid  input  1  issue strobe, marks iss_rd as pending.
REQ-014 SHALL: iss_rd  input  AW  destination register being issued.
REQ-015 SHALL: busy_vec  output  NREG  registered scoreboard state, bit i = register i pending.

Function
REQ-016 SHALL: register 0 reads as zero on both read ports regardless of writes, bypass or issue.
REQ-017 SHALL: writes with address 0 have no effect on storage or scoreboard.
REQ-018 SHALL: on rising edge with we[k]=1 and wa[k]!=0, register wa[k] takes wd[k].
REQ-019 SHALL: if several enabled ports target the same address in one cycle, the highest-index port wins for storage and bypass.
REQ-020 SHALL: with BYPASS=1, a read of address A while any enabled port writes A (A!=0) returns the winning port's wd in the same cycle.
REQ-021 SHALL: with BYPASS=0, a read of a register being written returns the pre-edge value; new value visible the cycle after.
REQ-022 SHALL: iss_valid=1 with iss_rd!=0 sets busy_vec[iss_rd] on the next edge; iss_rd=0 ignored.
REQ-023 SHALL: any enabled write to address A!=0 clears busy_vec[A] on the next edge.
REQ-024 SHALL: simultaneous issue and write to the same register leaves the bit set (new producer wins).
REQ-025 SHALL: issue to an already-busy register keeps it busy (no counting).
REQ-026 SHALL: rsN_busy = busy_vec[rsN_addr], except with BYPASS=1 it is 0 when an enabled port writes that address this cycle and no same-cycle issue targets it; always 0 for address 0.
REQ-027 SHALL: busy_vec[0] is constant 0.
REQ-028 SHALL: read path is purely combinational, zero-cycle latency; write and scoreboard latency exactly one edge.

Reset
REQ-029 SHALL: while rst_n=0 at an edge, all registers clear to 0 and busy_vec clears to all zeros; writes and issues in that cycle are discarded.
REQ-030 SHALL: during reset, rs1_data/rs2_data reflect stored contents (zero after first reset edge); bypass remains combinational on inputs.
REQ-031 SHALL: reset asserted mid-operation drops all pending busy bits with no residual state.

Structure
REQ-032 SHALL: package regfile_pkg holds XLEN/NREG defaults, AW derivation function, and the reg_idx_t typedef.
REQ-033 SHALL: scoreboard logic lives in sub-module regfile_scoreboard (inputs we, wa, iss_valid, iss_rd; output busy_vec).
REQ-034 SHALL: storage is a flat array of NREG x XLEN flops, entry 0 need not be physically stored.

Verification
REQ-035 SHALL: reset, then write port0 A=5 D=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF.
REQ-036 SHALL: we=2'b11, wa0=wa1=7, wd0=0x1, wd1=0x2, BYPASS=1, rs2_addr=7 -> rs2_data=0x2 same cycle and after edge.
REQ-037 SHALL: write 0xFFFFFFFF to address 0 and issue rd=0 -> rs1_data=0, busy_vec[0]=0.
REQ-038 SHALL: issue rd=9, next cycle rs1_busy=1; write 9 next -> rs1_busy=0 same cycle (BYPASS=1), busy_vec[9]=0 after edge; same-cycle issue 9 + write 9 -> busy_vec[9]=1.
REQ-039 SHALL: BYPASS=0, write A=3 D=0x55 while reading 3 -> old value this cycle, 0x55 next cycle.
REQ-040 SHALL: load registers and issue 4 destinations, assert rst_n=0 for one edge -> all reads 0, busy_vec=0.
